// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
//  ram_pkg : shared constants and state encoding for 16x8 RAM client blocks
//  Revision: 1.0
// ============================================================================
package ram_pkg;

  localparam int RAM_AW    = 4;
  localparam int RAM_DW    = 8;
  localparam int RAM_DEPTH = 1 << RAM_AW;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage : ram_pkg
`default_nettype wire

// File: rtl/ram_copy_master.sv
`default_nettype none
// ============================================================================
//  ram_copy_master : one-word-per-clock block copy / fill engine for a 16x8
//                    synchronous dual-port RAM with registered read data.
//  Revision: 1.0
// ============================================================================
module ram_copy_master
  import ram_pkg::*;
#(
  parameter int AW = RAM_AW,
  parameter int DW = RAM_DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          fill_en,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] fill_val,
  output logic          busy,
  output logic          done,
  output logic          ram_rd,
  output logic [AW-1:0] ram_r_add,
  output logic          ram_wr,
  output logic [AW-1:0] ram_w_add,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [AW:0] c_depth = (AW+1)'(1 << AW);

  state_t        r_state;
  logic          r_fill;
  logic [DW-1:0] r_fill_val;
  logic [AW-1:0] r_src;
  logic [AW-1:0] r_dst;
  logic [AW:0]   r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_rd;
  logic [AW-1:0] r_r_add;
  logic          r_wr;
  logic [AW-1:0] r_w_add;

  logic [AW:0]   w_len;

  assign w_len = (len > c_depth) ? c_depth : len;

  // r_src/r_dst hold the next address to issue; r_cnt counts words still to issue.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_fill     <= 1'b0;
      r_fill_val <= '0;
      r_src      <= '0;
      r_dst      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_rd       <= 1'b0;
      r_r_add    <= '0;
      r_wr       <= 1'b0;
      r_w_add    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          r_rd   <= 1'b0;
          r_wr   <= 1'b0;
          r_busy <= 1'b0;
          if (start) begin
            r_fill     <= fill_en;
            r_fill_val <= fill_val;
            if (w_len == '0) begin
              r_src   <= src_addr;
              r_dst   <= dst_addr;
              r_cnt   <= '0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_cnt   <= w_len - 1'b1;
              r_busy  <= 1'b1;
              r_state <= ST_RUN;
              if (fill_en) begin
                r_wr    <= 1'b1;
                r_w_add <= dst_addr;
                r_dst   <= dst_addr + 1'b1;
                r_src   <= src_addr;
              end else begin
                r_rd    <= 1'b1;
                r_r_add <= src_addr;
                r_src   <= src_addr + 1'b1;
                r_dst   <= dst_addr;
              end
            end
          end
        end

        ST_RUN: begin
          if (r_fill) begin
            if (r_cnt != '0) begin
              r_wr    <= 1'b1;
              r_w_add <= r_dst;
              r_dst   <= r_dst + 1'b1;
              r_cnt   <= r_cnt - 1'b1;
            end else begin
              r_wr    <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end else begin
            // Each cycle writes the word whose read was issued the cycle before.
            r_wr    <= 1'b1;
            r_w_add <= r_dst;
            r_dst   <= r_dst + 1'b1;
            if (r_cnt != '0) begin
              r_rd    <= 1'b1;
              r_r_add <= r_src;
              r_src   <= r_src + 1'b1;
              r_cnt   <= r_cnt - 1'b1;
            end else begin
              r_rd    <= 1'b0;
              r_state <= ST_DRAIN;
            end
          end
        end

        ST_DRAIN: begin
          r_wr    <= 1'b0;
          r_rd    <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= ST_DONE;
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_rd    <= 1'b0;
          r_wr    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign ram_rd    = r_rd;
  assign ram_r_add = r_r_add;
  assign ram_wr    = r_wr;
  assign ram_w_add = r_w_add;
  assign ram_din   = r_fill ? r_fill_val : ram_dout;

endmodule : ram_copy_master
`default_nettype wire

// File: tb/tb_ram_copy_master.sv
`default_nettype none
// ============================================================================
//  tb_ram_copy_master : randomized bench with a transaction-level RAM model
//  Revision: 1.0
// ============================================================================
module tb_ram_copy_master;
  import ram_pkg::*;

  localparam int D    = RAM_DEPTH;
  localparam int TMAX = 20;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              fill_en = 1'b0;
  logic [RAM_AW-1:0] src_addr = '0;
  logic [RAM_AW-1:0] dst_addr = '0;
  logic [RAM_AW:0]   len = '0;
  logic [RAM_DW-1:0] fill_val = '0;
  logic              busy, done, ram_rd, ram_wr;
  logic [RAM_AW-1:0] ram_r_add, ram_w_add;
  logic [RAM_DW-1:0] ram_din;
  logic [RAM_DW-1:0] ram_dout = '0;

  logic [RAM_DW-1:0] mem     [D];
  logic [RAM_DW-1:0] exp_mem [D];

  int checks = 0;
  int errors = 0;

  ram_copy_master dut (
    .clk(clk), .reset(reset), .start(start), .fill_en(fill_en),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len), .fill_val(fill_val),
    .busy(busy), .done(done), .ram_rd(ram_rd), .ram_r_add(ram_r_add),
    .ram_wr(ram_wr), .ram_w_add(ram_w_add), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  // RAM: read samples the old contents before the same-edge write lands.
  always @(posedge clk) begin
    if (ram_rd) ram_dout <= mem[ram_r_add];
    if (ram_wr) mem[ram_w_add] = ram_din;
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Expected per-cycle trace of one command, indexed by cycle after the start edge.
  int                tr_cyc = -1;
  int                e_n = 0;
  logic              e_busy [TMAX];
  logic              e_done [TMAX];
  logic              e_rd   [TMAX];
  logic              e_wr   [TMAX];
  logic [RAM_AW-1:0] e_ra   [TMAX];
  logic [RAM_AW-1:0] e_wa   [TMAX];
  logic [RAM_DW-1:0] e_din  [TMAX];

  task automatic build(input logic f, input logic [RAM_AW-1:0] s, input logic [RAM_AW-1:0] d,
                       input int l_raw, input logic [RAM_DW-1:0] fv);
    int l;
    logic [RAM_DW-1:0] tmp [D];
    logic [RAM_DW-1:0] v   [D];
    l = (l_raw > D) ? D : l_raw;
    for (int c = 0; c < TMAX; c++) begin
      e_busy[c] = 0; e_done[c] = 0; e_rd[c] = 0; e_wr[c] = 0;
      e_ra[c] = '0; e_wa[c] = '0; e_din[c] = '0;
    end
    if (l == 0) begin
      e_n = 1;
      e_done[0] = 1;
    end else if (f) begin
      e_n = l + 1;
      for (int c = 0; c < l; c++) begin
        e_busy[c] = 1; e_wr[c] = 1;
        e_wa[c] = RAM_AW'((int'(d) + c) % D);
        e_din[c] = fv;
      end
      e_done[l] = 1;
    end else begin
      // Word k is read while writes 0..k-2 have already landed.
      tmp = exp_mem;
      for (int k = 0; k < l; k++) begin
        v[k] = tmp[(int'(s) + k) % D];
        if (k >= 1) tmp[(int'(d) + k - 1) % D] = v[k-1];
      end
      e_n = l + 2;
      for (int c = 0; c <= l; c++) e_busy[c] = 1;
      for (int c = 0; c < l; c++) begin
        e_rd[c] = 1;
        e_ra[c] = RAM_AW'((int'(s) + c) % D);
      end
      for (int c = 1; c <= l; c++) begin
        e_wr[c] = 1;
        e_wa[c] = RAM_AW'((int'(d) + c - 1) % D);
        e_din[c] = v[c-1];
      end
      e_done[l+1] = 1;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      tr_cyc = -1;
    end else begin
      if (tr_cyc >= 0 && tr_cyc < e_n && e_wr[tr_cyc]) exp_mem[e_wa[tr_cyc]] = e_din[tr_cyc];
      if (start && (tr_cyc < 0 || tr_cyc >= e_n)) begin
        build(fill_en, src_addr, dst_addr, int'(len), fill_val);
        tr_cyc = 0;
      end else if (tr_cyc >= 0 && tr_cyc < e_n) begin
        tr_cyc++;
      end
    end
  end

  always @(negedge clk) begin
    logic xb, xd, xr, xw;
    logic [RAM_AW-1:0] xra, xwa;
    logic [RAM_DW-1:0] xdin;
    if (tr_cyc >= 0 && tr_cyc < e_n) begin
      xb = e_busy[tr_cyc]; xd = e_done[tr_cyc]; xr = e_rd[tr_cyc]; xw = e_wr[tr_cyc];
      xra = e_ra[tr_cyc]; xwa = e_wa[tr_cyc]; xdin = e_din[tr_cyc];
    end else begin
      xb = 0; xd = 0; xr = 0; xw = 0; xra = '0; xwa = '0; xdin = '0;
    end
    chk("busy", int'(busy), int'(xb));
    chk("done", int'(done), int'(xd));
    chk("ram_rd", int'(ram_rd), int'(xr));
    chk("ram_wr", int'(ram_wr), int'(xw));
    if (xr) chk("ram_r_add", int'(ram_r_add), int'(xra));
    if (xw) begin
      chk("ram_w_add", int'(ram_w_add), int'(xwa));
      chk("ram_din", int'(ram_din), int'(xdin));
    end
  end

  task automatic launch(input logic f, input logic [RAM_AW-1:0] s, input logic [RAM_AW-1:0] d,
                        input logic [RAM_AW:0] l, input logic [RAM_DW-1:0] fv);
    @(posedge clk); #2;
    fill_en = f; src_addr = s; dst_addr = d; len = l; fill_val = fv; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int nwr, output int nrd);
    bit hit;
    hit = 0; cyc = 0; nwr = 0; nrd = 0;
    while (!hit && cyc <= 60) begin
      @(negedge clk);
      if (done) hit = 1;
      else begin
        nwr += int'(ram_wr);
        nrd += int'(ram_rd);
        cyc++;
      end
    end
    if (!hit) chk("done_timeout", 0, 1);
  endtask

  task automatic mem_chk();
    for (int i = 0; i < D; i++) chk($sformatf("mem[%0d]", i), int'(mem[i]), int'(exp_mem[i]));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, nwr, nrd;
    for (int i = 0; i < D; i++) begin
      mem[i] = RAM_DW'(i + 20);
      exp_mem[i] = RAM_DW'(i + 20);
    end
    #1 reset = 1'b0;
    #1;
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    // Basic copy
    launch(1'b0, 4'd0, 4'd8, 5'd4, 8'h00);
    wait_done(cyc, nwr, nrd);
    chk("t2_done_cycle", cyc, 5);
    chk("t2_writes", nwr, 4);
    chk("t2_reads", nrd, 4);
    @(posedge clk); #2;
    chk("t2_mem8", int'(mem[8]), 20);
    chk("t2_mem11", int'(mem[11]), 23);
    mem_chk();

    // Wrapping copy
    launch(1'b0, 4'd14, 4'd2, 5'd4, 8'h00);
    wait_done(cyc, nwr, nrd);
    @(posedge clk); #2;
    chk("t3_mem2", int'(mem[2]), 34);
    chk("t3_mem3", int'(mem[3]), 35);
    chk("t3_mem4", int'(mem[4]), 20);
    chk("t3_mem5", int'(mem[5]), 21);
    mem_chk();

    // Reset in the middle of a copy, after the second write
    launch(1'b0, 4'd0, 4'd12, 5'd8, 8'h00);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_rd", int'(ram_rd), 0);
    chk("abort_wr", int'(ram_wr), 0);
    @(posedge clk); #2 reset = 1'b1;
    repeat (2) @(posedge clk); #2;
    chk("abort_mem12", int'(mem[12]), 20);
    chk("abort_mem13", int'(mem[13]), 21);
    chk("abort_mem14", int'(mem[14]), 34);
    mem_chk();
    launch(1'b0, 4'd12, 4'd6, 5'd3, 8'h00);
    wait_done(cyc, nwr, nrd);
    chk("post_abort_done_cycle", cyc, 4);
    @(posedge clk); #2;
    chk("post_abort_mem8", int'(mem[8]), 34);
    mem_chk();

    // Fill, then clamped fill
    launch(1'b1, 4'd0, 4'd12, 5'd6, 8'hA5);
    wait_done(cyc, nwr, nrd);
    chk("t4_done_cycle", cyc, 6);
    chk("t4_reads", nrd, 0);
    chk("t4_writes", nwr, 6);
    @(posedge clk); #2;
    chk("t4_mem1", int'(mem[1]), 8'hA5);
    mem_chk();
    launch(1'b1, 4'd0, 4'd3, 5'd20, 8'h5A);
    wait_done(cyc, nwr, nrd);
    chk("t4_clamp_writes", nwr, 16);
    chk("t4_clamp_done_cycle", cyc, 16);
    mem_chk();

    // Zero length, then starts that must be ignored
    launch(1'b1, 4'd0, 4'd0, 5'd0, 8'h77);
    wait_done(cyc, nwr, nrd);
    chk("t5_len0_done_cycle", cyc, 0);
    chk("t5_len0_writes", nwr + nrd, 0);
    launch(1'b1, 4'd0, 4'd4, 5'd5, 8'h3C);
    fill_en = 1'b1; dst_addr = 4'd0; len = 5'd16; fill_val = 8'h11; start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    wait_done(cyc, nwr, nrd);
    chk("t5_done_cycle_minus1", cyc, 4);
    start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
    repeat (3) @(posedge clk); #2;
    chk("t5_mem0", int'(mem[0]), 8'h5A);
    chk("t5_mem4", int'(mem[4]), 8'h3C);
    chk("t5_mem9", int'(mem[9]), 8'h5A);
    mem_chk();

    // Randomized commands, including overlaps and over-length requests
    for (int n = 0; n < 40; n++) begin
      launch(1'($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom),
             5'($urandom_range(0, 20)), 8'($urandom));
      wait_done(cyc, nwr, nrd);
      @(posedge clk); #2;
      mem_chk();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_ram_copy_master
`default_nettype wire
